// File: rtl/hex_fmt_pkg.sv
// Shared types, ASCII constants and helpers for the result hex formatter.
package hex_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HEX  = 3'd1,
    CR   = 3'd2,
    LF   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Index of the most significant nonzero nibble; 0 when the value is zero,
  // so at least one digit is always produced.
  function automatic logic [2:0] lead_nibble_idx(input logic [31:0] value);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (value[i*4 +: 4] != 4'h0) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational mapping of one hex nibble to its ASCII character.
module nibble_to_ascii
  import hex_fmt_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // Digits map onto '0'..'9'; 10..15 map onto the selected letter case.
  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = ASCII_0 + {4'h0, i_nibble};
    end else begin
      o_ascii = (UPPERCASE ? ASCII_UA : ASCII_LA) + {4'h0, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/result_hex_tx.sv
// Latches a 32-bit product and streams it as ASCII hex (MS nibble first),
// optionally followed by CR LF, over a valid/ready byte handshake.
module result_hex_tx
  import hex_fmt_pkg::*;
#(
  parameter bit SUPPRESS_ZEROS = 1'b1,
  parameter bit UPPERCASE      = 1'b1,
  parameter bit NEWLINE        = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        alu_done,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        fmt_done,
  output logic        overrun
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_shadow;
  logic [31:0] w_shadow_next;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic        r_overrun;
  logic        w_overrun_next;
  logic [3:0]  w_nibble;
  logic [7:0]  w_hex_char;

  assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];
  assign overrun  = r_overrun;

  nibble_to_ascii #(
    .UPPERCASE (UPPERCASE)
  ) u_nibble_to_ascii (
    .i_nibble (w_nibble),
    .o_ascii  (w_hex_char)
  );

  // State, shadow, nibble index and sticky overrun registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shadow  <= 32'h0;
      r_idx     <= 3'd0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shadow  <= w_shadow_next;
      r_idx     <= w_idx_next;
      r_overrun <= w_overrun_next;
    end
  end

  // Next-state and output decode. Outputs depend only on registered state,
  // so tx_valid never depends combinationally on tx_ready.
  always_comb begin
    w_state_next   = r_state;
    w_shadow_next  = r_shadow;
    w_idx_next     = r_idx;
    w_overrun_next = r_overrun;
    tx_data        = 8'h00;
    tx_valid       = 1'b0;
    busy           = 1'b0;
    fmt_done       = 1'b0;

    // A result is accepted only in IDLE; anywhere else (including DONE and
    // the cycle of the final transfer) it is dropped and flagged.
    if (alu_done) begin
      if (r_state == IDLE) begin
        w_shadow_next  = result;
        w_idx_next     = SUPPRESS_ZEROS ? lead_nibble_idx(result) : 3'd7;
        w_overrun_next = 1'b0;
        w_state_next   = HEX;
      end else begin
        w_overrun_next = 1'b1;
      end
    end

    case (r_state)
      IDLE: ;
      HEX: begin
        tx_data  = w_hex_char;
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready) begin
          if (r_idx != 3'd0) w_idx_next = r_idx - 3'd1;
          else               w_state_next = NEWLINE ? CR : DONE;
        end
      end
      CR: begin
        tx_data  = ASCII_CR;
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready) w_state_next = LF;
      end
      LF: begin
        tx_data  = ASCII_LF;
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready) w_state_next = DONE;
      end
      DONE: begin
        fmt_done     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_hex_tx.sv
// Self-checking bench: two formatter configurations share one stimulus and
// are compared against a string-based model of the expected character stream.
module tb_result_hex_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result;
  logic        alu_done;
  logic        tx_ready;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_valid_a, tx_valid_b;
  logic        busy_a, busy_b;
  logic        fmt_done_a, fmt_done_b;
  logic        overrun_a, overrun_b;

  int errors = 0;
  int checks = 0;
  bit rdy_rand = 1'b0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int xfer_a = 0, xfer_b = 0;
  int fmt_cnt_a = 0, fmt_cnt_b = 0;
  logic       pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;
  logic [7:0] pd_a = 8'h00, pd_b = 8'h00;

  always #5 clk = ~clk;

  result_hex_tx #(.SUPPRESS_ZEROS(1'b1), .UPPERCASE(1'b1), .NEWLINE(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .result(result), .alu_done(alu_done), .tx_ready(tx_ready),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .busy(busy_a), .fmt_done(fmt_done_a),
    .overrun(overrun_a));

  result_hex_tx #(.SUPPRESS_ZEROS(1'b0), .UPPERCASE(1'b0), .NEWLINE(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .result(result), .alu_done(alu_done), .tx_ready(tx_ready),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .busy(busy_b), .fmt_done(fmt_done_b),
    .overrun(overrun_b));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the text a human would expect for a value in a given format.
  function automatic string fmt_ref(input logic [31:0] v, input bit sz, input bit uc, input bit nl);
    string digits;
    string s;
    digits = "0123456789ABCDEF";
    s = "";
    for (int i = 7; i >= 0; i--) begin
      int k;
      k = int'(v[i*4 +: 4]);
      s = {s, digits.substr(k, k)};
    end
    if (!uc) s = s.tolower();
    if (sz) while (s.len() > 1 && s.substr(0, 0) == "0") s = s.substr(1, s.len() - 1);
    if (nl) s = {s, "\r\n"};
    return s;
  endfunction

  // Ready generator: tied high or pseudo-random, updated just after each edge.
  always @(posedge clk) begin
    #1;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: inputs are stable from negedge to posedge, so valid&&ready seen
  // here is exactly the transfer that the next rising edge performs.
  always @(negedge clk) begin
    if (rst) begin
      pv_a = 1'b0; pv_b = 1'b0;
    end else begin
      if (pv_a && !pr_a) begin
        check_val("hold_valid_a", tx_valid_a, 1);
        check_val("hold_data_a", tx_data_a, pd_a);
      end
      if (pv_b && !pr_b) begin
        check_val("hold_valid_b", tx_valid_b, 1);
        check_val("hold_data_b", tx_data_b, pd_b);
      end
      if (tx_valid_a && tx_ready) begin
        xfer_a++;
        if (qa.size() == 0) check_val("extra_byte_a", qa.size(), 1);
        else check_val("byte_a", tx_data_a, qa.pop_front());
      end
      if (tx_valid_b && tx_ready) begin
        xfer_b++;
        if (qb.size() == 0) check_val("extra_byte_b", qb.size(), 1);
        else check_val("byte_b", tx_data_b, qb.pop_front());
      end
      if (fmt_done_a) fmt_cnt_a++;
      if (fmt_done_b) fmt_cnt_b++;
      pv_a = tx_valid_a; pr_a = tx_ready; pd_a = tx_data_a;
      pv_b = tx_valid_b; pr_b = tx_ready; pd_b = tx_data_b;
    end
  end

  task automatic queue_expected(input logic [31:0] v, output int la, output int lb);
    string sa, sb;
    sa = fmt_ref(v, 1'b1, 1'b1, 1'b1);
    sb = fmt_ref(v, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < sa.len(); i++) qa.push_back(sa[i]);
    for (int i = 0; i < sb.len(); i++) qb.push_back(sb[i]);
    la = sa.len();
    lb = sb.len();
  endtask

  task automatic pulse_done(input logic [31:0] v);
    @(posedge clk); #1;
    result = v; alu_done = 1'b1;
    @(posedge clk); #1;
    alu_done = 1'b0;
  endtask

  // One transaction; optionally checks latency/timing (ready tied high) and
  // optionally fires a second alu_done after dup_at bytes have moved.
  task automatic run(input logic [31:0] v, input bit chk_lat, input int dup_at);
    int la, lb, da, db, base_a, fa, fb;
    bit dup_done, dup_live;
    queue_expected(v, la, lb);
    base_a = xfer_a; fa = fmt_cnt_a; fb = fmt_cnt_b;
    dup_done = 1'b0; dup_live = 1'b0;
    pulse_done(v);
    da = -1; db = -1;
    for (int n = 0; n < 3000 && (da < 0 || db < 0); n++) begin
      @(negedge clk);
      if (dup_live) begin alu_done = 1'b0; dup_live = 1'b0; end
      if (n == 0 && chk_lat) check_val("latency_valid_a", tx_valid_a, 1);
      if (n == 0) check_val("busy_a", busy_a, 1);
      if (fmt_done_a && da < 0) da = n;
      if (fmt_done_b && db < 0) db = n;
      if (dup_at >= 0 && !dup_done && (xfer_a - base_a) == dup_at) begin
        result = 32'h5; alu_done = 1'b1; dup_done = 1'b1; dup_live = 1'b1;
      end
    end
    alu_done = 1'b0;
    check_val("done_seen_a", (da >= 0), 1);
    check_val("done_seen_b", (db >= 0), 1);
    if (chk_lat) begin
      check_val("done_cycle_a", da, la);
      check_val("done_cycle_b", db, lb);
    end
    check_val("busy_low_a", busy_a, 0);
    @(negedge clk);
    check_val("fmt_pulses_a", fmt_cnt_a - fa, 1);
    check_val("fmt_pulses_b", fmt_cnt_b - fb, 1);
    check_val("left_a", qa.size(), 0);
    check_val("left_b", qb.size(), 0);
    $display("txn result=%h bytes_a=%0d bytes_b=%0d", v, la, lb);
  endtask

  initial begin
    int la, lb;
    logic [31:0] v;
    rst = 1'b1; result = 32'h0; alu_done = 1'b0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_data", tx_data_a, 8'h00);
    check_val("rst_valid", tx_valid_a, 0);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_fmt", fmt_done_a, 0);
    check_val("rst_ovr", overrun_a, 0);
    @(posedge clk); #1; rst = 1'b0;

    run(32'h0000000C, 1'b1, -1);
    run(32'd169, 1'b1, -1);
    run(32'h00000000, 1'b1, -1);
    check_val("ovr_clear_a", overrun_a, 0);

    rdy_rand = 1'b1;
    run(32'hDEADBEEF, 1'b0, 4);
    check_val("ovr_set_a", overrun_a, 1);
    check_val("ovr_set_b", overrun_b, 1);
    run(32'h00000005, 1'b0, -1);
    check_val("ovr_clr_a", overrun_a, 0);
    check_val("ovr_clr_b", overrun_b, 0);

    for (int i = 0; i < 8; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      run(v, 1'b0, -1);
    end

    // Asynchronous reset in the middle of a stream.
    queue_expected($urandom | 32'h10000000, la, lb);
    pulse_done(32'hA5A5A5A5 | 32'h10000000);
    qa.delete(); qb.delete();
    queue_expected(32'hA5A5A5A5 | 32'h10000000, la, lb);
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("arst_valid_a", tx_valid_a, 0);
    check_val("arst_data_a", tx_data_a, 8'h00);
    check_val("arst_busy_a", busy_a, 0);
    check_val("arst_valid_b", tx_valid_b, 0);
    check_val("arst_busy_b", busy_b, 0);
    check_val("arst_fmt_a", fmt_done_a, 0);
    check_val("arst_ovr_a", overrun_a, 0);
    qa.delete(); qb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    run(32'h0000001F, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_hex_tx.md
Name: result_hex_tx

Overview:
Sink for the multiplier's result/alu_done output. Latches the 32-bit unsigned product and streams it to the UART transmitter as ASCII hex characters (most significant nibble first), followed by CR LF. Uses a valid/ready byte handshake toward the UART TX. Sits between unsigned_mul and the UART TX in the hex calculator datapath.

Parameters:
SUPPRESS_ZEROS, 1, 1 = skip leading zero nibbles (at least one digit is always sent); 0 = always send 8 digits.
UPPERCASE, 1, 1 = A-F as 8'h41-8'h46; 0 = a-f as 8'h61-8'h66.
NEWLINE, 1, 1 = append CR (8'h0D) then LF (8'h0A); 0 = no terminator.

Ports:
clk  input  1  system clock. One clock domain; all logic on the rising edge.
rst  input  1  reset, asynchronous and active-high.
result  input  32  unsigned product from the ALU; valid in the cycle alu_done=1.
alu_done  input  1  single-cycle pulse: result valid.
tx_ready  input  1  UART TX can accept a byte this cycle.
tx_data  output  8  ASCII byte offered to the UART TX.
tx_valid  output  1  tx_data valid.
busy  output  1  high from acceptance of alu_done until the last byte transfers.
fmt_done  output  1  one-cycle pulse after the last byte transfers.
overrun  output  1  sticky flag: an alu_done arrived while busy.

Behaviour:
- Reset (async, active-high): tx_data=8'h00, tx_valid=0, busy=0, fmt_done=0, overrun=0, state=IDLE. Reset mid-stream aborts the stream; the next byte is never sent.
- Transfer: one byte moves on each rising edge where tx_valid && tx_ready. While tx_valid=1 and tx_ready=0, tx_data holds stable and tx_valid stays high. tx_valid does not depend combinationally on tx_ready.
- States: IDLE, HEX, CR, LF, DONE.
- IDLE: on alu_done=1, latch result into a 32-bit shadow register.
  - Set the nibble index to 7, or, if SUPPRESS_ZEROS=1, to the highest nonzero nibble (0 when result=0).
  - busy=1, overrun cleared, go to HEX.
  - tx_valid=1 with the first character in the cycle after alu_done (1-cycle latency).
- HEX: tx_data = ASCII of the shadow nibble at the index. On transfer:
  - index>0: decrement the index.
  - index=0: go to CR if NEWLINE=1, else DONE.
- CR: tx_data=8'h0D; on transfer go to LF.
- LF: tx_data=8'h0A; on transfer go to DONE.
- DONE: tx_valid=0, busy=0, fmt_done=1 for exactly one cycle, then IDLE. An alu_done in the DONE cycle counts as during busy.
- Nibble encoding: 0-9 -> 8'h30+n; 10-15 -> 8'h41+(n-10), or 8'h61+(n-10) when UPPERCASE=0.
- alu_done while state != IDLE: ignored (the shadow register is unchanged) and overrun is set to 1. overrun stays set until the next accepted alu_done or reset.
- alu_done in the same cycle as the final transfer: ignored (state is not yet IDLE); overrun is set.
- Output bytes per result: digits + 2 (NEWLINE=1). Digits range from 1 to 8.

Decomposition:
- Package hex_fmt_pkg:
  - state enum {IDLE, HEX, CR, LF, DONE}.
  - constants ASCII_0=8'h30, ASCII_UA=8'h41, ASCII_LA=8'h61, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - function for the leading-nonzero-nibble index.
- Sub-module nibble_to_ascii: combinational 4-bit -> 8-bit mapping, with the UPPERCASE parameter passed down.
- FSM, shadow register, index counter and handshake stay in result_hex_tx.

Test Plan:
- tx_ready tied 1, result=32'h0000000C (3*4), alu_done pulse -> tx_valid rises the next cycle; bytes 8'h43, 8'h0D, 8'h0A on 3 consecutive cycles; then fmt_done pulses once and busy falls.
- result=32'd169 (13*13) -> bytes 8'h41 ('A'), 8'h39 ('9'), 8'h0D, 8'h0A; with UPPERCASE=0 the first byte is 8'h61.
- result=32'h0 -> bytes 8'h30, 8'h0D, 8'h0A. With SUPPRESS_ZEROS=0 -> eight 8'h30 then CR LF.
- result=32'hDEADBEEF, tx_ready toggling pseudo-randomly -> exactly "DEADBEEF\r\n" transferred. tx_data is stable whenever tx_valid=1 and tx_ready=0; no byte is duplicated or dropped.
- Second alu_done with result=32'h5 during the 'B' of DEADBEEF -> the stream is unchanged, overrun=1. The next idle alu_done with result=32'h5 sends "5\r\n" and clears overrun.
- rst asserted asynchronously mid-stream (between clock edges) -> all outputs return to reset values immediately. After release, a new alu_done with result=32'h1F sends "1F\r\n".
